// File: rtl/display_scheduler.sv
// Screen FSM and album-art scroll offset for the VGA datapath.
// Screen changes and scroll position are committed only on frame_start, so each frame is consistent.
module display_scheduler #(
  parameter int unsigned SCROLL_MAX  = 240,
  parameter int unsigned STEP_NORMAL = 1,
  parameter int unsigned STEP_FAST   = 4,
  parameter int unsigned OFS_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             tick,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_enter,
  input  logic             btn_back,
  input  logic             play,
  input  logic             next,
  input  logic             forward,
  input  logic             backward,
  input  logic [1:0]       music_sel,
  output logic [1:0]       mainstate,
  output logic [OFS_W-1:0] scroll_offset,
  output logic             paused
);

  localparam logic [1:0] StMenuPlay   = 2'd0;
  localparam logic [1:0] StMenuCredit = 2'd1;
  localparam logic [1:0] StPlaying    = 2'd2;
  localparam logic [1:0] StCredit     = 2'd3;

  // One extra bit so offset + step never overflows before the wrap compare.
  localparam logic [OFS_W:0] MaxExt  = (OFS_W + 1)'(SCROLL_MAX);
  localparam logic [OFS_W:0] FastExt = (OFS_W + 1)'(STEP_FAST);
  localparam logic [OFS_W:0] NormExt = (OFS_W + 1)'(STEP_NORMAL);

  logic [1:0]       mainstate_q, mainstate_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_state_q, pend_state_d;
  logic [OFS_W-1:0] offset_q, offset_d;
  logic [OFS_W-1:0] scroll_q, scroll_d;
  logic             paused_q, paused_d;
  logic [1:0]       sel_q, sel_d;

  logic [1:0]       work_state;
  logic             req_valid;
  logic [1:0]       req_state;
  logic             accept_req;
  logic             commit;
  logic             enter_play;
  logic             playing;
  logic             restart;

  logic [OFS_W:0]   off_ext;
  logic [OFS_W:0]   inc_step;
  logic [OFS_W:0]   inc_res;
  logic [OFS_W:0]   dec_res;

  // Requested screen transition, evaluated on the state including any pending request.
  always_comb begin
    work_state = pend_valid_q ? pend_state_q : mainstate_q;
    req_valid  = 1'b0;
    req_state  = work_state;
    case (work_state)
      StMenuPlay: begin
        if (btn_enter) begin
          req_valid = 1'b1;
          req_state = StPlaying;
        end else if (btn_down && !btn_up) begin
          req_valid = 1'b1;
          req_state = StMenuCredit;
        end
      end
      StMenuCredit: begin
        if (btn_enter) begin
          req_valid = 1'b1;
          req_state = StCredit;
        end else if (btn_up && !btn_down) begin
          req_valid = 1'b1;
          req_state = StMenuPlay;
        end
      end
      StPlaying: begin
        if (btn_back) begin
          req_valid = 1'b1;
          req_state = StMenuPlay;
        end
      end
      StCredit: begin
        if (btn_back) begin
          req_valid = 1'b1;
          req_state = StMenuCredit;
        end
      end
      default: begin
        req_valid = 1'b0;
      end
    endcase
  end

  // A frame_start opens a new frame, so a request in that same cycle starts the next pending slot.
  always_comb begin
    accept_req   = req_valid && (frame_start || !pend_valid_q);
    commit       = frame_start && pend_valid_q;
    enter_play   = commit && (pend_state_q == StPlaying);

    pend_valid_d = pend_valid_q && !frame_start;
    pend_state_d = pend_state_q;
    if (accept_req) begin
      pend_valid_d = 1'b1;
      pend_state_d = req_state;
    end

    mainstate_d = commit ? pend_state_q : mainstate_q;
  end

  // Wrapping increment and decrement of the working offset.
  always_comb begin
    off_ext  = {1'b0, offset_q};
    inc_step = (forward && !backward) ? FastExt : NormExt;
    inc_res  = off_ext + inc_step;
    if (inc_res >= MaxExt) begin
      inc_res = inc_res - MaxExt;
    end
    if (off_ext < FastExt) begin
      dec_res = off_ext + MaxExt - FastExt;
    end else begin
      dec_res = off_ext - FastExt;
    end
  end

  always_comb begin
    playing  = (mainstate_q == StPlaying);
    restart  = playing && (next || (music_sel != sel_q));
    sel_d    = music_sel;

    offset_d = offset_q;
    if (enter_play || restart) begin
      offset_d = '0;
    end else if (playing && !paused_q && tick) begin
      if (backward && !forward) begin
        offset_d = dec_res[OFS_W-1:0];
      end else begin
        offset_d = inc_res[OFS_W-1:0];
      end
    end

    paused_d = paused_q;
    if (enter_play) begin
      paused_d = 1'b0;
    end else if (playing && play) begin
      paused_d = !paused_q;
    end

    // Pre-tick working offset is what the new frame shows.
    scroll_d = frame_start ? offset_q : scroll_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainstate_q  <= StMenuPlay;
      pend_valid_q <= 1'b0;
      pend_state_q <= StMenuPlay;
      offset_q     <= '0;
      scroll_q     <= '0;
      paused_q     <= 1'b0;
      sel_q        <= 2'd0;
    end else begin
      mainstate_q  <= mainstate_d;
      pend_valid_q <= pend_valid_d;
      pend_state_q <= pend_state_d;
      offset_q     <= offset_d;
      scroll_q     <= scroll_d;
      paused_q     <= paused_d;
      sel_q        <= sel_d;
    end
  end

  assign mainstate     = mainstate_q;
  assign scroll_offset = scroll_q;
  assign paused        = paused_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_display_scheduler;

  localparam int MAX  = 240;
  localparam int NORM = 1;
  localparam int FAST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       tick = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_enter = 1'b0;
  logic       btn_back = 1'b0;
  logic       play = 1'b0;
  logic       next = 1'b0;
  logic       forward = 1'b0;
  logic       backward = 1'b0;
  logic [1:0] music_sel = 2'd0;
  logic [1:0] mainstate;
  logic [8:0] scroll_offset;
  logic       paused;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: m_pend < 0 means no request waiting for a frame.
  int m_state, m_pend, m_off, m_scroll, m_paused, m_sel;

  display_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .tick          (tick),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_enter     (btn_enter),
    .btn_back      (btn_back),
    .play          (play),
    .next          (next),
    .forward       (forward),
    .backward      (backward),
    .music_sel     (music_sel),
    .mainstate     (mainstate),
    .scroll_offset (scroll_offset),
    .paused        (paused)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Screen reached from s by the current button pulses, -1 if none.
  function automatic int next_screen(input int s);
    case (s)
      0: begin
        if (btn_enter) return 2;
        if (btn_down && !btn_up) return 1;
      end
      1: begin
        if (btn_enter) return 3;
        if (btn_up && !btn_down) return 0;
      end
      2: if (btn_back) return 0;
      3: if (btn_back) return 1;
      default: ;
    endcase
    return -1;
  endfunction

  task automatic model_edge();
    int o_state, o_pend, o_off, o_paused, ns;
    bit pl;
    if (rst) begin
      m_state = 0; m_pend = -1; m_off = 0; m_scroll = 0; m_paused = 0; m_sel = 0;
      return;
    end
    o_state  = m_state;
    o_pend   = m_pend;
    o_off    = m_off;
    o_paused = m_paused;
    pl       = (o_state == 2);

    ns = next_screen((o_pend >= 0) ? o_pend : o_state);
    if (frame_start) m_pend = -1;
    if (ns >= 0 && (frame_start || o_pend < 0)) m_pend = ns;
    if (frame_start && o_pend >= 0) m_state = o_pend;

    if (frame_start) m_scroll = o_off;

    if (frame_start && o_pend == 2) begin
      m_off = 0;
      m_paused = 0;
    end else begin
      if (pl && (next || int'(music_sel) != m_sel)) m_off = 0;
      else if (pl && o_paused == 0 && tick) begin
        if (forward && !backward)      m_off = (o_off + FAST) % MAX;
        else if (backward && !forward) m_off = (o_off + MAX - FAST) % MAX;
        else                           m_off = (o_off + NORM) % MAX;
      end
      if (pl && play) m_paused = 1 - o_paused;
    end
    m_sel = int'(music_sel);
  endtask

  // One clock: model follows the sampled inputs, outputs compared, pulses cleared.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("model_mainstate", int'(mainstate), m_state);
    check_eq("model_scroll", int'(scroll_offset), m_scroll);
    check_eq("model_paused", int'(paused), m_paused);
    frame_start = 1'b0; tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    btn_enter = 1'b0; btn_back = 1'b0; play = 1'b0; next = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    cyc();
  endtask

  initial begin
    // Reset, enter at cycle 10, frame at cycle 50.
    cyc();
    rst = 1'b0;
    check_eq("rst_mainstate", int'(mainstate), 0);
    check_eq("rst_scroll", int'(scroll_offset), 0);
    check_eq("rst_paused", int'(paused), 0);
    idle(9);
    btn_enter = 1'b1;
    cyc();
    idle(39);
    check_eq("pre_frame_mainstate", int'(mainstate), 0);
    frame();
    check_eq("enter_commit", int'(mainstate), 2);
    check_eq("enter_scroll", int'(scroll_offset), 0);
    check_eq("enter_paused", int'(paused), 0);

    // Full revolution of the scroll range.
    for (int i = 1; i <= MAX; i++) begin
      ticks(1);
      frame();
      check_eq("wrap_seq", int'(scroll_offset), i % MAX);
    end

    // Backward wrap and both-held behaviour.
    ticks(2);
    backward = 1'b1;
    ticks(1);
    frame();
    check_eq("backward_wrap", int'(scroll_offset), 238);
    forward = 1'b1;
    ticks(1);
    frame();
    check_eq("both_held", int'(scroll_offset), 239);
    forward = 1'b0;
    backward = 1'b0;

    // Menu navigation, first request per frame wins.
    btn_back = 1'b1; cyc();
    frame();
    check_eq("back_to_menu", int'(mainstate), 0);
    btn_down = 1'b1; cyc();
    btn_enter = 1'b1; cyc();
    frame();
    check_eq("first_req_wins", int'(mainstate), 1);
    btn_enter = 1'b1; cyc();
    frame();
    check_eq("credit", int'(mainstate), 3);
    btn_back = 1'b1; cyc();
    frame();
    check_eq("credit_back", int'(mainstate), 1);
    btn_up = 1'b1; cyc();
    frame();
    btn_enter = 1'b1; cyc();
    frame();
    check_eq("replay", int'(mainstate), 2);

    // Pause freezes the offset; play outside PLAYING is ignored.
    ticks(17);
    play = 1'b1; cyc();
    ticks(10);
    frame();
    check_eq("pause_offset", int'(scroll_offset), 17);
    check_eq("pause_flag", int'(paused), 1);
    btn_back = 1'b1; cyc();
    frame();
    play = 1'b1; cyc();
    check_eq("play_in_menu", int'(paused), 1);
    btn_enter = 1'b1; cyc();
    frame();
    check_eq("reenter_unpause", int'(paused), 0);

    // Track change beats a same-cycle tick.
    music_sel = 2'd1; cyc();
    ticks(100);
    frame();
    check_eq("offset_100", int'(scroll_offset), 100);
    music_sel = 2'd2;
    ticks(1);
    frame();
    check_eq("track_restart", int'(scroll_offset), 0);

    // Reset discards a pending request.
    ticks(5);
    play = 1'b1; cyc();
    btn_back = 1'b1; cyc();
    frame();
    check_eq("pre_rst_scroll", int'(scroll_offset), 5);
    btn_enter = 1'b1; cyc();
    rst = 1'b1; cyc();
    rst = 1'b0;
    check_eq("rst_mid_mainstate", int'(mainstate), 0);
    check_eq("rst_mid_scroll", int'(scroll_offset), 0);
    check_eq("rst_mid_paused", int'(paused), 0);
    frame();
    check_eq("pending_dropped", int'(mainstate), 0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 799) == 0);
      frame_start = ($urandom_range(0, 11) == 0);
      tick        = ($urandom_range(0, 2) == 0);
      btn_up      = ($urandom_range(0, 19) == 0);
      btn_down    = ($urandom_range(0, 19) == 0);
      btn_enter   = ($urandom_range(0, 15) == 0);
      btn_back    = ($urandom_range(0, 29) == 0);
      play        = ($urandom_range(0, 29) == 0);
      next        = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) forward = ~forward;
      if ($urandom_range(0, 39) == 0) backward = ~backward;
      if ($urandom_range(0, 99) == 0) music_sel = 2'($urandom_range(0, 3));
      cyc();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
Sequences the VGA display datapath: owns the screen FSM that drives mainstate into the VGA top and computes the album-art scroll offset (play/pause, forward/backward, track change). All visible changes (screen switch, scroll position) are committed only on the frame_start pulse, so no frame shows a mix of two screens or two scroll positions. Sits between the debounced button/one-pulse logic and the VGA top / address generators.

Parameters:
SCROLL_MAX, 240, scroll range in lines; offset wraps modulo this value (must be > STEP_FAST)
STEP_NORMAL, 1, offset change per tick during normal play
STEP_FAST, 4, offset change per tick while forward or backward is held
OFS_W, 9, width of the scroll offset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
frame_start  input  1  one-cycle pulse at the start of each VGA frame (vsync domain, already synchronised to clk)
tick  input  1  one-cycle scroll-rate pulse from the clock divisor
btn_up  input  1  one-cycle pulse, menu up
btn_down  input  1  one-cycle pulse, menu down
btn_enter  input  1  one-cycle pulse, select
btn_back  input  1  one-cycle pulse, return
play  input  1  one-cycle pulse, toggle pause
next  input  1  one-cycle pulse, restart current track scroll
forward  input  1  level, fast scroll forward
backward  input  1  level, fast scroll backward
music_sel  input  2  selected track
mainstate  output  2  committed screen: 0 title/play-highlight, 1 title/credit-highlight, 2 playing, 3 credit
scroll_offset  output  OFS_W  committed scroll offset, stable for a whole frame
paused  output  1  1 = scroll frozen

Behaviour:
- Reset (sync, rst high at clk edge): internal state and mainstate = 0, pending request cleared, working offset = 0, scroll_offset = 0, paused = 0, stored music_sel = 0.
- Screen FSM transitions on button pulses (computed on the working state, which includes any pending request):
  - MENU_PLAY(0): btn_down -> MENU_CREDIT; btn_enter -> PLAYING; btn_up ignored.
  - MENU_CREDIT(1): btn_up -> MENU_PLAY; btn_enter -> CREDIT.
  - PLAYING(2): btn_back -> MENU_PLAY.
  - CREDIT(3): btn_back -> MENU_CREDIT.
  - Same-cycle priority: back > enter > up/down. Up and down together = no move.
- Commit: a transition is stored as a pending request; the first request in a frame wins and later button pulses in that frame are ignored. On frame_start the pending request is written to mainstate one cycle later (mainstate changes in the cycle after frame_start), and the pending request is cleared. A button pulse in the same cycle as frame_start is committed at the following frame_start.
- Entering PLAYING (at commit): working offset = 0, paused = 0.
- paused: toggles on play only while mainstate = 2; play in any other state is ignored.
- Working offset updates on tick only while mainstate = 2 and paused = 0:
  - forward only: + STEP_FAST.
  - backward only: - STEP_FAST.
  - neither, or both: + STEP_NORMAL. Both held is treated as normal play.
  - Wrap: if sum >= SCROLL_MAX, subtract SCROLL_MAX. If offset < step on decrement, result = offset + SCROLL_MAX - step. Working offset is always in 0..SCROLL_MAX-1.
- Track restart: next pulse, or music_sel differing from its registered copy, sets working offset = 0. This takes priority over a same-cycle tick. paused is unchanged.
- scroll_offset is loaded from the working offset on frame_start (visible the next cycle) and holds otherwise. A tick coinciding with frame_start commits the pre-tick value.
- Outside PLAYING the working offset holds its value. In CREDIT the credit roll is clocked independently and is not controlled by this block.

Test Plan:
- Reset, then btn_enter at cycle 10, frame_start at cycle 50 -> mainstate = 0 until cycle 50, = 2 at cycle 51; scroll_offset = 0, paused = 0.
- In PLAYING, 239 ticks then 1 tick with frame_start after each -> committed offsets 1..239, then 0 (wrap at SCROLL_MAX).
- Offset 2, backward held, one tick -> working offset 238 (2 + 240 - 4); forward and backward both held, one tick -> 239.
- btn_down then btn_enter in the same frame from MENU_PLAY -> only MENU_CREDIT is committed (mainstate = 1); a second btn_enter in the next frame -> mainstate = 3; btn_back -> 1.
- play pulse in PLAYING at offset 17, 10 ticks -> offset stays 17, paused = 1; play in MENU_PLAY -> paused unchanged.
- music_sel 1->2 in the same cycle as a tick at offset 100 -> working offset 0; rst asserted mid-frame with a pending request -> all outputs 0 on the next cycle and the pending request is discarded.
